// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// Load/store controller between the MEM pipeline stage and a word-addressed
// data memory. Byte/halfword/word requests at byte addresses become word
// accesses; sub-word stores use read-modify-write. One response per accepted
// request; the pipeline is stalled while the controller is busy.
//
// Optional feature macro: DMEM_BOUNDS_CHECK_EN
//    defined   : nonzero req_addr[31:ADDR_W+2] is an access error
//    undefined : those bits are ignored and the address wraps
//
// Parameters
//    ADDR_W      word-index width of the memory
//    MEM_RD_LAT  cycles from memread high to valid read_data (1..4)
//
// Ports
//    clk, rst                synchronous active-high reset
//    req_valid/req_ready     request handshake (accept in IDLE)
//    req_we, req_size, req_signed, req_addr, req_wdata   request fields
//    resp_valid, resp_rdata, resp_err                     one-cycle response
//    stall                   ~req_ready
//    mem_addr, mem_write_data, mem_memread, mem_memwrite, mem_read_data
//                            data-memory interface
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a request, no strobes
// RD_WAIT | memread held for MEM_RD_LAT cycles, data sampled on last edge
// WR      | memwrite for one cycle with the full word
// RESP    | resp_valid pulse, then back to IDLE
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
   parameter int ADDR_W     = 8,
   parameter int MEM_RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              stall,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_write_data,
   output logic              mem_memread,
   output logic              mem_memwrite,
   input  logic [31:0]       mem_read_data
);

   // One-hot encoding so every strobe is a direct flop output.
   typedef enum logic [3:0] {
      IDLE    = 4'b0001,
      RD_WAIT = 4'b0010,
      WR      = 4'b0100,
      RESP    = 4'b1000
   } state_t;

   localparam logic [2:0] CNT_INIT = 3'(MEM_RD_LAT - 1);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q;
   logic        we_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic [1:0]  off_q;
   logic [15:0] wdata_q;
   logic        err_q;

   logic        misalign;
   logic        oob;
   logic        req_err;
   logic        word_store;

   always_comb begin
      misalign = 1'b0;
      case (req_size)
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = req_addr[0];
         2'b10:   misalign = |req_addr[1:0];
         default: misalign = 1'b1;
      endcase
   end

`ifdef DMEM_BOUNDS_CHECK_EN
   assign oob = |req_addr[31:ADDR_W+2];
`else
   assign oob = 1'b0;
   wire unused_addr_hi = ^req_addr[31:ADDR_W+2];
`endif

   assign req_err    = misalign | oob;
   assign word_store = req_we & (req_size == 2'b10);

   function automatic logic [31:0] extract(input logic [31:0] w,
                                           input logic [1:0]  sz,
                                           input logic        sgn,
                                           input logic [1:0]  off);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (sz)
         2'b00:   extract = {{24{sgn & b[7]}}, b};
         2'b01:   extract = {{16{sgn & h[15]}}, h};
         default: extract = w;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w,
                                         input logic [1:0]  sz,
                                         input logic [1:0]  off,
                                         input logic [15:0] d);
      logic [31:0] m;
      m = w;
      if (sz == 2'b00)
         m[{off, 3'b000} +: 8] = d[7:0];
      else if (off[1])
         m[31:16] = d;
      else
         m[15:0] = d;
      merge = m;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_err)         state_d = RESP;
               else if (word_store) state_d = WR;
               else                 state_d = RD_WAIT;
            end
         end
         RD_WAIT: if (cnt_q == 3'd0) state_d = we_q ? WR : RESP;
         WR:      state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q          <= 3'd0;
         we_q           <= 1'b0;
         size_q         <= 2'b00;
         signed_q       <= 1'b0;
         off_q          <= 2'b00;
         wdata_q        <= 16'h0;
         err_q          <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= 32'h0;
         resp_rdata     <= 32'h0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  we_q       <= req_we;
                  size_q     <= req_size;
                  signed_q   <= req_signed;
                  off_q      <= req_addr[1:0];
                  wdata_q    <= req_wdata[15:0];
                  err_q      <= req_err;
                  cnt_q      <= CNT_INIT;
                  mem_addr   <= req_addr[ADDR_W+1:2];
                  resp_rdata <= 32'h0;
                  if (word_store) mem_write_data <= req_wdata;
               end
            end
            RD_WAIT: begin
               if (cnt_q == 3'd0) begin
                  if (we_q) mem_write_data <= merge(mem_read_data, size_q, off_q, wdata_q);
                  else      resp_rdata     <= extract(mem_read_data, size_q, signed_q, off_q);
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready    = state_q[0];
   assign mem_memread  = state_q[1];
   assign mem_memwrite = state_q[2];
   assign resp_valid   = state_q[3];
   assign resp_err     = state_q[3] & err_q;
   assign stall        = ~state_q[0];

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              stall;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_write_data;
   logic              mem_memread;
   logic              mem_memwrite;
   logic [31:0]       mem_read_data;

   int n_checks = 0;
   int n_fail   = 0;

   dmem_access_ctrl #(.ADDR_W(ADDR_W), .MEM_RD_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .stall(stall), .mem_addr(mem_addr),
      .mem_write_data(mem_write_data), .mem_memread(mem_memread),
      .mem_memwrite(mem_memwrite), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   // Memory model, read latency 1: data valid during the memread cycle.
   logic [31:0]       mem [256];
   logic              bd_we = 1'b0;
   logic [ADDR_W-1:0] bd_addr = '0;
   logic [31:0]       bd_data = 32'h0;

   assign mem_read_data = mem_memread ? mem[mem_addr] : 32'h0;

   always @(posedge clk) begin
      if (mem_memwrite)  mem[mem_addr] <= mem_write_data;
      else if (bd_we)    mem[bd_addr]  <= bd_data;
   end

   typedef struct {
      logic [31:0]       rdata;
      logic              err;
      int                lat;
      int                nrd;
      int                nwr;
      logic [31:0]       wdata;
      logic [ADDR_W-1:0] maddr;
   } exp_t;

   exp_t sb_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic expect_quiet(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("quiet_resp_valid", 32'(resp_valid), 32'h0);
         check("quiet_memwrite",   32'(mem_memwrite), 32'h0);
      end
   endtask

   task automatic do_req(input string name, input logic we, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                         input int e_nrd, input int e_nwr, input logic [31:0] e_wdata,
                         input logic [ADDR_W-1:0] e_maddr, input logic noise);
      exp_t e, got;
      int nrd, nwr, lat;
      logic overlap, addr_moved, stall_bad;
      logic [31:0] wdat;
      logic [ADDR_W-1:0] maddr;
      e.rdata = e_rdata; e.err = e_err; e.lat = e_lat; e.nrd = e_nrd;
      e.nwr = e_nwr; e.wdata = e_wdata; e.maddr = e_maddr;
      @(negedge clk);
      check({name, "_ready_before"}, 32'(req_ready), 32'h1);
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
      req_addr = addr; req_wdata = wd;
      sb_q.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
      nrd = 0; nwr = 0; lat = 0; overlap = 0; addr_moved = 0; stall_bad = 0;
      wdat = 32'h0; maddr = '0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         if (stall !== ~req_ready) stall_bad = 1'b1;
         if (mem_memread & mem_memwrite) overlap = 1'b1;
         if (mem_memread | mem_memwrite) begin
            if ((nrd + nwr) == 0) maddr = mem_addr;
            else if (mem_addr !== maddr) addr_moved = 1'b1;
         end
         if (mem_memread)  nrd++;
         if (mem_memwrite) begin nwr++; wdat = mem_write_data; end
         if (noise && cyc == 1) begin
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
            req_addr = 32'h0000_0030; req_wdata = 32'h5555_5555;
         end else begin
            req_valid = 1'b0;
         end
         if (resp_valid) begin
            lat = cyc;
            break;
         end
      end
      req_valid = 1'b0;
      if (lat == 0) begin
         check({name, "_timeout"}, 32'h0, 32'h1);
      end else if (sb_q.size() == 0) begin
         check({name, "_unexpected_resp"}, 32'h1, 32'h0);
      end else begin
         got = sb_q.pop_front();
         check({name, "_rdata"}, resp_rdata, got.rdata);
         check({name, "_err"},   32'(resp_err), 32'(got.err));
         check({name, "_lat"},   32'(lat), 32'(got.lat));
         check({name, "_nrd"},   32'(nrd), 32'(got.nrd));
         check({name, "_nwr"},   32'(nwr), 32'(got.nwr));
         check({name, "_overlap"}, 32'(overlap), 32'h0);
         check({name, "_stall"},   32'(stall_bad), 32'h0);
         if (got.nwr != 0) check({name, "_wdata"}, wdat, got.wdata);
         if ((got.nrd + got.nwr) != 0) begin
            check({name, "_maddr"}, 32'(maddr), 32'(got.maddr));
            check({name, "_maddr_stable"}, 32'(addr_moved), 32'h0);
         end
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready",    32'(req_ready), 32'h1);
      check("rst_stall",    32'(stall), 32'h0);
      check("rst_rvalid",   32'(resp_valid), 32'h0);
      check("rst_rerr",     32'(resp_err), 32'h0);
      check("rst_memread",  32'(mem_memread), 32'h0);
      check("rst_memwrite", 32'(mem_memwrite), 32'h0);
      check("rst_rdata",    resp_rdata, 32'h0);
      check("rst_maddr",    32'(mem_addr), 32'h0);
      check("rst_mwdata",   mem_write_data, 32'h0);
      rst = 1'b0;

      // Word load
      poke(8'd4, 32'hDEAD_BEEF);
      do_req("lw10", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 2, 1, 0, 32'h0, 8'd4, 0);

      // Sub-word loads with sign/zero extension
      poke(8'd4, 32'h80FF_7F01);
      do_req("lb13",  0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFF_FF80, 0, 2, 1, 0, 32'h0, 8'd4, 0);
      do_req("lbu13", 0, 2'b00, 0, 32'h13, 32'h0, 32'h0000_0080, 0, 2, 1, 0, 32'h0, 8'd4, 0);
      do_req("lh12",  0, 2'b01, 1, 32'h12, 32'h0, 32'hFFFF_80FF, 0, 2, 1, 0, 32'h0, 8'd4, 0);
      do_req("lhu10", 0, 2'b01, 0, 32'h10, 32'h0, 32'h0000_7F01, 0, 2, 1, 0, 32'h0, 8'd4, 0);
      do_req("lb10s", 0, 2'b00, 1, 32'h10, 32'h0, 32'h0000_0001, 0, 2, 1, 0, 32'h0, 8'd4, 0);
      do_req("lb11s", 0, 2'b00, 1, 32'h11, 32'h0, 32'h0000_007F, 0, 2, 1, 0, 32'h0, 8'd4, 0);
      do_req("lws",   0, 2'b10, 1, 32'h10, 32'h0, 32'h80FF_7F01, 0, 2, 1, 0, 32'h0, 8'd4, 1);
      expect_quiet(4);

      // Read-modify-write stores
      poke(8'd8, 32'h1122_3344);
      do_req("sb21", 1, 2'b00, 0, 32'h21, 32'h0000_00AA, 32'h0, 0, 3, 1, 1, 32'h1122_AA44, 8'd8, 0);
      check("sb21_mem", mem[8], 32'h1122_AA44);
      do_req("sh22", 1, 2'b01, 0, 32'h22, 32'h0000_BEEF, 32'h0, 0, 3, 1, 1, 32'hBEEF_AA44, 8'd8, 0);
      check("sh22_mem", mem[8], 32'hBEEF_AA44);

      // Word store and read-back
      do_req("sw24", 1, 2'b10, 0, 32'h24, 32'hCAFE_F00D, 32'h0, 0, 2, 0, 1, 32'hCAFE_F00D, 8'd9, 0);
      do_req("lw24", 0, 2'b10, 0, 32'h24, 32'h0, 32'hCAFE_F00D, 0, 2, 1, 0, 32'h0, 8'd9, 0);

      // Alignment errors
      do_req("sh03",  1, 2'b01, 0, 32'h03, 32'h1234, 32'h0, 1, 1, 0, 0, 32'h0, 8'd0, 0);
      do_req("sz11",  0, 2'b11, 0, 32'h00, 32'h0,    32'h0, 1, 1, 0, 0, 32'h0, 8'd0, 0);
      do_req("sw02",  1, 2'b10, 0, 32'h02, 32'h9999, 32'h0, 1, 1, 0, 0, 32'h0, 8'd0, 0);
      do_req("lh21",  0, 2'b01, 1, 32'h21, 32'h0,    32'h0, 1, 1, 0, 0, 32'h0, 8'd0, 0);
      check("sw02_mem_untouched", mem[9], 32'hCAFE_F00D);

      // Address above the memory size
      poke(8'd0, 32'h0123_4567);
`ifdef DMEM_BOUNDS_CHECK_EN
      do_req("lw400", 0, 2'b10, 0, 32'h400, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 8'd0, 0);
`else
      do_req("lw400", 0, 2'b10, 0, 32'h400, 32'h0, 32'h0123_4567, 0, 2, 1, 0, 32'h0, 8'd0, 0);
`endif

      // Reset during the WR cycle of a sub-word store
      poke(8'd8, 32'h1122_3344);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h20; req_wdata = 32'h55;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rstwr_rd_phase", 32'(mem_memread), 32'h1);
      @(negedge clk);
      check("rstwr_wr_phase", 32'(mem_memwrite), 32'h1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rstwr_memwrite", 32'(mem_memwrite), 32'h0);
      check("rstwr_rvalid",   32'(resp_valid), 32'h0);
      check("rstwr_ready",    32'(req_ready), 32'h1);
      @(negedge clk);
      rst = 1'b0;
      expect_quiet(3);

      // Reset during RD_WAIT: the write never happens
      poke(8'd8, 32'h1122_3344);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h20; req_wdata = 32'h55;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rstrd_rd_phase", 32'(mem_memread), 32'h1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rstrd_memread", 32'(mem_memread), 32'h0);
      check("rstrd_ready",   32'(req_ready), 32'h1);
      check("rstrd_mwdata",  mem_write_data, 32'h0);
      check("rstrd_maddr",   32'(mem_addr), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      expect_quiet(3);
      check("rstrd_mem", mem[8], 32'h1122_3344);

      // Controller still usable after an abort
      do_req("lw_after", 0, 2'b10, 0, 32'h20, 32'h0, 32'h1122_3344, 0, 2, 1, 0, 32'h0, 8'd8, 0);
      check("sb_empty", 32'(sb_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
